// File: rtl/dual_issue_ctrl.sv
// Dual-issue front-end controller: decides dual/single/stall/flush for the IF/ID pair,
// sequences split pairs over two cycles and keeps saturating issue statistics.
module dual_issue_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pair_valid,
  input  logic [RA_W-1:0]  a_rs,
  input  logic [RA_W-1:0]  a_rt,
  input  logic             a_rs_used,
  input  logic             a_rt_used,
  input  logic [RA_W-1:0]  a_rd,
  input  logic             a_wr,
  input  logic             a_mem,
  input  logic             a_ctrl,
  input  logic [RA_W-1:0]  b_rs,
  input  logic [RA_W-1:0]  b_rt,
  input  logic             b_rs_used,
  input  logic             b_rt_used,
  input  logic             b_mem,
  input  logic             ex_load,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             redirect,
  output logic             if_id_hold,
  output logic             pc_hold,
  output logic             issue_a,
  output logic             issue_b,
  output logic             flush,
  output logic             split_state,
  output logic [CNT_W-1:0] cnt_dual,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_stall
);

  typedef enum logic {ISSUE = 1'b0, SECOND = 1'b1} state_t;

  state_t state, state_nxt;
  logic   lu_a, lu_b, dep_ab, split;
  logic   hold_c, issue_a_c, issue_b_c, flush_c, stall_c;

  // Register 0 is hard-wired, so it never forms a hazard.
  assign lu_a = ex_load && (ex_rd != '0) &&
                ((a_rs_used && (a_rs == ex_rd)) || (a_rt_used && (a_rt == ex_rd)));
  assign lu_b = ex_load && (ex_rd != '0) &&
                ((b_rs_used && (b_rs == ex_rd)) || (b_rt_used && (b_rt == ex_rd)));
  assign dep_ab = a_wr && (a_rd != '0) &&
                  ((b_rs_used && (b_rs == a_rd)) || (b_rt_used && (b_rt == a_rd)));
  assign split = dep_ab || (a_mem && b_mem) || a_ctrl || lu_b;

  always_comb begin
    // NOTE: every signal gets a default before the branches so no latch is inferred.
    state_nxt = state;
    hold_c    = 1'b0;
    issue_a_c = 1'b0;
    issue_b_c = 1'b0;
    flush_c   = 1'b0;
    stall_c   = 1'b0;
    if (redirect) begin
      flush_c   = 1'b1;
      state_nxt = ISSUE;
    end else if (pair_valid) begin
      unique case (state)
        ISSUE: begin
          if (lu_a) begin
            hold_c  = 1'b1;
            stall_c = 1'b1;
          end else if (split) begin
            hold_c    = 1'b1;
            issue_a_c = 1'b1;
            state_nxt = SECOND;
          end else begin
            issue_a_c = 1'b1;
            issue_b_c = 1'b1;
          end
        end
        SECOND: begin
          // Slot A now sits in ID/EX, so only slot B's load-use hazard matters.
          if (lu_b) begin
            hold_c  = 1'b1;
            stall_c = 1'b1;
          end else begin
            issue_b_c = 1'b1;
            state_nxt = ISSUE;
          end
        end
        default: state_nxt = ISSUE;
      endcase
    end
  end

  // Outputs are forced low for as long as reset is held.
  assign if_id_hold  = rst_n && hold_c;
  assign pc_hold     = rst_n && hold_c;
  assign issue_a     = rst_n && issue_a_c;
  assign issue_b     = rst_n && issue_b_c;
  assign flush       = rst_n && flush_c;
  assign split_state = rst_n && (state == SECOND);

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ISSUE;
      cnt_dual   <= '0;
      cnt_single <= '0;
      cnt_stall  <= '0;
    end else begin
      state <= state_nxt;
      if (issue_a_c && issue_b_c && (cnt_dual != '1))
        cnt_dual <= cnt_dual + CNT_W'(1);
      if ((issue_a_c ^ issue_b_c) && (cnt_single != '1))
        cnt_single <= cnt_single + CNT_W'(1);
      if (stall_c && (cnt_stall != '1))
        cnt_stall <= cnt_stall + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Directed bench for dual_issue_ctrl; a second CNT_W=4 instance exercises saturation.
module tb_dual_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pair_valid;
  logic [4:0] a_rs, a_rt, a_rd, b_rs, b_rt, ex_rd;
  logic       a_rs_used, a_rt_used, a_wr, a_mem, a_ctrl;
  logic       b_rs_used, b_rt_used, b_mem, ex_load, redirect;
  logic       if_id_hold, pc_hold, issue_a, issue_b, flush, split_state;
  logic [31:0] cnt_dual, cnt_single, cnt_stall;
  logic       h4_if, h4_pc, ia4, ib4, fl4, ss4;
  logic [3:0] cd4, cs4, cst4;
  logic [5:0] outs;

  int checks = 0;
  int errors = 0;

  assign outs = {if_id_hold, pc_hold, issue_a, issue_b, flush, split_state};

  always #5 clk = ~clk;

  dual_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pair_valid(pair_valid),
    .a_rs(a_rs), .a_rt(a_rt), .a_rs_used(a_rs_used), .a_rt_used(a_rt_used),
    .a_rd(a_rd), .a_wr(a_wr), .a_mem(a_mem), .a_ctrl(a_ctrl),
    .b_rs(b_rs), .b_rt(b_rt), .b_rs_used(b_rs_used), .b_rt_used(b_rt_used),
    .b_mem(b_mem), .ex_load(ex_load), .ex_rd(ex_rd), .redirect(redirect),
    .if_id_hold(if_id_hold), .pc_hold(pc_hold), .issue_a(issue_a), .issue_b(issue_b),
    .flush(flush), .split_state(split_state),
    .cnt_dual(cnt_dual), .cnt_single(cnt_single), .cnt_stall(cnt_stall)
  );

  dual_issue_ctrl #(.RA_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .pair_valid(pair_valid),
    .a_rs(a_rs), .a_rt(a_rt), .a_rs_used(a_rs_used), .a_rt_used(a_rt_used),
    .a_rd(a_rd), .a_wr(a_wr), .a_mem(a_mem), .a_ctrl(a_ctrl),
    .b_rs(b_rs), .b_rt(b_rt), .b_rs_used(b_rs_used), .b_rt_used(b_rt_used),
    .b_mem(b_mem), .ex_load(ex_load), .ex_rd(ex_rd), .redirect(redirect),
    .if_id_hold(h4_if), .pc_hold(h4_pc), .issue_a(ia4), .issue_b(ib4),
    .flush(fl4), .split_state(ss4),
    .cnt_dual(cd4), .cnt_single(cs4), .cnt_stall(cst4)
  );

  // Independent pair: A = add r3,r1,r2 ; B reads r4,r5. Hazard inputs idle.
  task automatic indep_pair();
    pair_valid = 1'b1; redirect = 1'b0;
    a_rs = 5'd1; a_rt = 5'd2; a_rs_used = 1'b1; a_rt_used = 1'b1;
    a_rd = 5'd3; a_wr = 1'b1; a_mem = 1'b0; a_ctrl = 1'b0;
    b_rs = 5'd4; b_rt = 5'd5; b_rs_used = 1'b1; b_rt_used = 1'b1; b_mem = 1'b0;
    ex_load = 1'b0; ex_rd = 5'd0;
  endtask

  // Advance one clock edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    indep_pair();
    #1;
    checks++; if (outs !== 6'b000000) begin errors++; $display("FAIL reset_outs got %b want %b", outs, 6'b000000); end
    checks++; if ({cnt_dual, cnt_single, cnt_stall} !== 96'd0) begin errors++; $display("FAIL reset_cnts got %0d/%0d/%0d want 0/0/0", cnt_dual, cnt_single, cnt_stall); end
    tick();
    rst_n = 1'b1;
    pair_valid = 1'b0;
    #1;
    checks++; if (outs !== 6'b000000) begin errors++; $display("FAIL bubble_outs got %b want %b", outs, 6'b000000); end
  endtask

  task automatic test_independent();
    indep_pair();
    #1;
    checks++; if (outs !== 6'b001100) begin errors++; $display("FAIL t1_outs got %b want %b", outs, 6'b001100); end
    tick();
    checks++; if (cnt_dual !== 32'd1) begin errors++; $display("FAIL t1_cnt_dual got %0d want 1", cnt_dual); end
  endtask

  task automatic test_dep_ab();
    indep_pair();
    b_rs = 5'd3;
    #1;
    checks++; if (outs !== 6'b111000) begin errors++; $display("FAIL t2_c0 got %b want %b", outs, 6'b111000); end
    tick();
    checks++; if (outs !== 6'b000101) begin errors++; $display("FAIL t2_c1 got %b want %b", outs, 6'b000101); end
    tick();
    pair_valid = 1'b0;
    #1;
    checks++; if (outs !== 6'b000000) begin errors++; $display("FAIL t2_back_issue got %b want %b", outs, 6'b000000); end
    checks++; if (cnt_single !== 32'd2) begin errors++; $display("FAIL t2_cnt_single got %0d want 2", cnt_single); end
    tick();
    checks++; if ({cnt_dual, cnt_single, cnt_stall} !== {32'd1, 32'd2, 32'd0}) begin errors++; $display("FAIL bubble_cnts got %0d/%0d/%0d want 1/2/0", cnt_dual, cnt_single, cnt_stall); end
  endtask

  task automatic test_load_use();
    indep_pair();
    a_rs = 5'd7; ex_load = 1'b1; ex_rd = 5'd7;
    #1;
    checks++; if (outs !== 6'b110000) begin errors++; $display("FAIL t3_stall got %b want %b", outs, 6'b110000); end
    tick();
    checks++; if (cnt_stall !== 32'd1) begin errors++; $display("FAIL t3_cnt_stall got %0d want 1", cnt_stall); end
    ex_load = 1'b0;
    #1;
    checks++; if (outs !== 6'b001100) begin errors++; $display("FAIL t3_resume got %b want %b", outs, 6'b001100); end
    tick();
    checks++; if (cnt_dual !== 32'd2) begin errors++; $display("FAIL t3_cnt_dual got %0d want 2", cnt_dual); end
  endtask

  task automatic test_r0_and_splits();
    // r0 as writer, reader and load destination: no hazard at all.
    indep_pair();
    a_rd = 5'd0; a_rs = 5'd0; b_rs = 5'd0; ex_load = 1'b1; ex_rd = 5'd0;
    #1;
    checks++; if (outs !== 6'b001100) begin errors++; $display("FAIL t4_r0 got %b want %b", outs, 6'b001100); end
    tick();
    checks++; if (cnt_dual !== 32'd3) begin errors++; $display("FAIL t4_cnt_dual got %0d want 3", cnt_dual); end
    indep_pair();
    a_mem = 1'b1; b_mem = 1'b1;
    #1;
    checks++; if (outs !== 6'b111000) begin errors++; $display("FAIL t4_mem_c0 got %b want %b", outs, 6'b111000); end
    tick();
    checks++; if (outs !== 6'b000101) begin errors++; $display("FAIL t4_mem_c1 got %b want %b", outs, 6'b000101); end
    tick();
    indep_pair();
    a_ctrl = 1'b1;
    #1;
    checks++; if (outs !== 6'b111000) begin errors++; $display("FAIL t4_ctrl_c0 got %b want %b", outs, 6'b111000); end
    tick();
    checks++; if (outs !== 6'b000101) begin errors++; $display("FAIL t4_ctrl_c1 got %b want %b", outs, 6'b000101); end
    tick();
    checks++; if (cnt_single !== 32'd6) begin errors++; $display("FAIL t4_cnt_single got %0d want 6", cnt_single); end
  endtask

  task automatic test_lu_b_second();
    // Load into r9 that only slot B reads: split, then stall in SECOND.
    indep_pair();
    b_rt = 5'd9; ex_load = 1'b1; ex_rd = 5'd9;
    #1;
    checks++; if (outs !== 6'b111000) begin errors++; $display("FAIL lub_c0 got %b want %b", outs, 6'b111000); end
    tick();
    checks++; if (outs !== 6'b110001) begin errors++; $display("FAIL lub_stall got %b want %b", outs, 6'b110001); end
    tick();
    checks++; if (cnt_stall !== 32'd2) begin errors++; $display("FAIL lub_cnt_stall got %0d want 2", cnt_stall); end
    ex_load = 1'b0;
    #1;
    checks++; if (outs !== 6'b000101) begin errors++; $display("FAIL lub_issue_b got %b want %b", outs, 6'b000101); end
    tick();
    checks++; if (cnt_single !== 32'd8) begin errors++; $display("FAIL lub_cnt_single got %0d want 8", cnt_single); end
  endtask

  task automatic test_redirect();
    indep_pair();
    b_rs = 5'd3;
    tick();
    pair_valid = 1'b0;
    #1;
    checks++; if (outs !== 6'b000001) begin errors++; $display("FAIL t5_bubble_second got %b want %b", outs, 6'b000001); end
    tick();
    pair_valid = 1'b1; redirect = 1'b1;
    #1;
    checks++; if (outs !== 6'b000011) begin errors++; $display("FAIL t5_flush got %b want %b", outs, 6'b000011); end
    tick();
    checks++; if ({cnt_dual, cnt_single, cnt_stall} !== {32'd3, 32'd9, 32'd2}) begin errors++; $display("FAIL t5_cnts got %0d/%0d/%0d want 3/9/2", cnt_dual, cnt_single, cnt_stall); end
    checks++; if (outs !== 6'b000010) begin errors++; $display("FAIL t5_flush_issue got %b want %b", outs, 6'b000010); end
    redirect = 1'b0;
    #1;
    checks++; if (outs !== 6'b111000) begin errors++; $display("FAIL t5_after got %b want %b", outs, 6'b111000); end
  endtask

  task automatic test_saturation_reset();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    indep_pair();
    for (int i = 0; i < 16; i++) tick();
    checks++; if (cd4 !== 4'd15) begin errors++; $display("FAIL t6_sat got %0d want 15", cd4); end
    checks++; if (cnt_dual !== 32'd16) begin errors++; $display("FAIL t6_wide got %0d want 16", cnt_dual); end
    tick();
    checks++; if (cd4 !== 4'd15) begin errors++; $display("FAIL t6_sat_hold got %0d want 15", cd4); end
    b_rs = 5'd3;
    tick();
    checks++; if (outs !== 6'b000101) begin errors++; $display("FAIL t6_second got %b want %b", outs, 6'b000101); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (outs !== 6'b000000) begin errors++; $display("FAIL t6_rst_outs got %b want %b", outs, 6'b000000); end
    checks++; if ({cnt_dual, cnt_single, cnt_stall, cd4} !== 100'd0) begin errors++; $display("FAIL t6_rst_cnts got %0d/%0d/%0d/%0d want 0", cnt_dual, cnt_single, cnt_stall, cd4); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (outs !== 6'b111000) begin errors++; $display("FAIL t6_post_rst got %b want %b", outs, 6'b111000); end
  endtask

  initial begin
    test_reset();
    test_independent();
    test_dep_ab();
    test_load_use();
    test_r0_and_splits();
    test_lu_b_second();
    test_redirect();
    test_saturation_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
